// File: rtl/uart_rx_engine.sv
`timescale 1ns / 1ps
// uart_rx_engine
//   Asynchronous serial receiver, 8 data bits LSB first, one stop bit.
//   The line is oversampled at 16x the bit rate; each bit is sampled once at
//   its mid-point, counted from the centre of the start bit.
//
//   Build option: define UART_RX_PARITY_EN to receive 8E1 (even parity bit
//   between the data and stop bits). Left undefined, the block receives 8N1.
//
// Parameters
//   freq_hz   system clock frequency in Hz
//   baud      serial bit rate
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   uart_rxd  asynchronous serial input, idle high
//   rx_data   last received byte
//   rx_avail  an unread byte is held in rx_data
//   rx_error  framing, parity or overrun error
//   rx_ack    one-cycle pulse from the consumer: byte and error consumed
module uart_rx_engine #(
  parameter int unsigned freq_hz = 25000000,
  parameter int unsigned baud    = 38400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack
);

  // Clocks per 16x oversample tick (integer floor).
  localparam int unsigned DIV    = freq_hz / (16 * baud);
  localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]        sample_cnt_q, sample_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_avail_q, rx_avail_d;
  logic              rx_error_q, rx_error_d;
`ifdef UART_RX_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  logic tick;
  logic mid_bit;
  logic rx_s;

  assign rx_s    = sync2_q;
  assign tick    = (tick_cnt_q == TICK_MAX);
  // After the start-bit centre the sample counter wraps every 16 ticks,
  // so a wrap marks the centre of each following bit.
  assign mid_bit = tick && (sample_cnt_q == 4'd15);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    sync1_d      = uart_rxd;
    sync2_d      = sync1_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    // An acknowledge consumes the byte and the error; a byte completing in
    // the same cycle overrides this below.
    rx_avail_d   = rx_avail_q & ~rx_ack;
    rx_error_d   = rx_error_q & ~rx_ack;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        sample_cnt_d = '0;
        bit_cnt_d    = '0;
        if (!rx_s) state_d = ST_START;
      end

      ST_START: begin
        if (tick) begin
          if (sample_cnt_q == 4'd7) begin
            // Start-bit centre: a line back high was only a glitch.
            sample_cnt_d = '0;
            state_d      = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (tick) sample_cnt_d = sample_cnt_q + 4'd1;
        if (mid_bit) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) sample_cnt_d = sample_cnt_q + 4'd1;
        if (mid_bit) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          parity_err_d = rx_s ^ (^shift_q);
          state_d      = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (tick) sample_cnt_d = sample_cnt_q + 4'd1;
        if (mid_bit) begin
          if (!rx_s) begin
            // Framing error; wait for the line to recover so a break is
            // not taken as a stream of zero bytes.
            rx_error_d = 1'b1;
            state_d    = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (parity_err_q) begin
            rx_error_d = 1'b1;
            state_d    = ST_IDLE;
`endif
          end else begin
            rx_data_d  = shift_q;
            rx_avail_d = 1'b1;
            // Unconsumed previous byte is overrun; a simultaneous ack
            // leaves the default (cleared) error in place.
            if (rx_avail_q && !rx_ack) rx_error_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this edge.
    if (reset) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      tick_cnt_q   <= '0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_avail_q   <= 1'b0;
      rx_error_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_cnt_q   <= tick_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_avail_q   <= rx_avail_d;
      rx_error_q   <= rx_error_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_avail = rx_avail_q;
  assign rx_error = rx_error_q;

endmodule
